// File: rtl/wash_cycle_ctrl.sv
// Washing-machine programme sequencer: FILL -> WASH -> RINSE x RINSE_CNT -> SPIN -> DONE,
// with pause, abort-to-spin and a done/ack handshake. Optional macro WASH_LEVEL_SENSE_EN adds a water-level FILL timeout.
module wash_cycle_ctrl #(
    parameter int CNT_W       = 8,
    parameter int FILL_TICKS  = 4,
    parameter int WASH_TICKS  = 6,
    parameter int RINSE_TICKS = 3,
    parameter int SPIN_TICKS  = 5,
    parameter int RINSE_CNT   = 2,
    parameter int RPT_W       = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             abort_i,
    input  logic             ack_i,
`ifdef WASH_LEVEL_SENSE_EN
    input  logic             level_ok_i,
    output logic             fault_o,
`endif
    output logic [2:0]       stage_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             aborted_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic [RPT_W-1:0] rinse_idx_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_WASH  = 3'd2;
    localparam logic [2:0] ST_RINSE = 3'd3;
    localparam logic [2:0] ST_SPIN  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
`ifdef WASH_LEVEL_SENSE_EN
    localparam logic [2:0] ST_FAULT = 3'd7;
`endif

    // Counter load values; a zero-length stage still lasts one cycle.
    localparam logic [CNT_W-1:0] FILL_LD  = (FILL_TICKS  == 0) ? '0 : CNT_W'(FILL_TICKS  - 1);
    localparam logic [CNT_W-1:0] WASH_LD  = (WASH_TICKS  == 0) ? '0 : CNT_W'(WASH_TICKS  - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = (RINSE_TICKS == 0) ? '0 : CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = (SPIN_TICKS  == 0) ? '0 : CNT_W'(SPIN_TICKS  - 1);
    localparam logic [RPT_W-1:0] RINSE_LAST = (RINSE_CNT <= 1) ? '0 : RPT_W'(RINSE_CNT - 1);

    logic [2:0]       stage_q, stage_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [RPT_W-1:0] rinse_idx_q, rinse_idx_d;
    logic             aborted_q, aborted_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             stage_end_s;
`ifdef WASH_LEVEL_SENSE_EN
    logic             fault_q, fault_d;
`endif

    // Stage-end condition: counter expiry, or early FILL completion on water level.
    always_comb begin
`ifdef WASH_LEVEL_SENSE_EN
        stage_end_s = (remaining_q == {CNT_W{1'b0}}) || ((stage_q == ST_FILL) && level_ok_i);
`else
        stage_end_s = (remaining_q == {CNT_W{1'b0}});
`endif
    end

    // Next-state logic; abort outranks pause, which outranks counting.
    always_comb begin
        stage_d     = stage_q;
        remaining_d = remaining_q;
        rinse_idx_d = rinse_idx_q;
        aborted_d   = aborted_q;
        case (stage_q)
            ST_IDLE: begin
                if (start_i && !pause_i) begin
                    stage_d     = ST_FILL;
                    remaining_d = FILL_LD;
                    rinse_idx_d = '0;
                    aborted_d   = 1'b0;
                end else begin
                    remaining_d = '0;
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (abort_i && (stage_q != ST_SPIN)) begin
                    stage_d     = ST_SPIN;
                    remaining_d = SPIN_LD;
                    aborted_d   = 1'b1;
                end else if (pause_i) begin
                    aborted_d = aborted_q | abort_i;
                end else if (!stage_end_s) begin
                    aborted_d   = aborted_q | abort_i;
                    remaining_d = remaining_q - CNT_W'(1);
                end else begin
                    aborted_d = aborted_q | abort_i;
                    case (stage_q)
                        ST_FILL: begin
`ifdef WASH_LEVEL_SENSE_EN
                            if (level_ok_i) begin
                                stage_d     = ST_WASH;
                                remaining_d = WASH_LD;
                            end else begin
                                stage_d     = ST_FAULT;
                                remaining_d = '0;
                            end
`else
                            stage_d     = ST_WASH;
                            remaining_d = WASH_LD;
`endif
                        end
                        ST_WASH: begin
                            stage_d     = ST_RINSE;
                            remaining_d = RINSE_LD;
                        end
                        ST_RINSE: begin
                            if (rinse_idx_q < RINSE_LAST) begin
                                rinse_idx_d = rinse_idx_q + RPT_W'(1);
                                remaining_d = RINSE_LD;
                            end else begin
                                stage_d     = ST_SPIN;
                                remaining_d = SPIN_LD;
                            end
                        end
                        default: begin
                            stage_d     = ST_DONE;
                            remaining_d = '0;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                remaining_d = '0;
                if (ack_i) begin
                    stage_d = ST_IDLE;
                end else begin
                    stage_d = ST_DONE;
                end
            end
`ifdef WASH_LEVEL_SENSE_EN
            ST_FAULT: begin
                remaining_d = '0;
                if (ack_i && !pause_i) begin
                    stage_d = ST_IDLE;
                end else begin
                    stage_d = ST_FAULT;
                end
            end
`endif
            default: begin
                stage_d     = ST_IDLE;
                remaining_d = '0;
                rinse_idx_d = '0;
                aborted_d   = 1'b0;
            end
        endcase
    end

    // Status flags are decoded from the next stage so they register alongside it.
    always_comb begin
        done_d = (stage_d == ST_DONE);
        busy_d = (stage_d == ST_FILL) || (stage_d == ST_WASH) ||
                 (stage_d == ST_RINSE) || (stage_d == ST_SPIN);
`ifdef WASH_LEVEL_SENSE_EN
        fault_d = (stage_d == ST_FAULT);
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q     <= ST_IDLE;
            remaining_q <= '0;
            rinse_idx_q <= '0;
            aborted_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef WASH_LEVEL_SENSE_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            stage_q     <= stage_d;
            remaining_q <= remaining_d;
            rinse_idx_q <= rinse_idx_d;
            aborted_q   <= aborted_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef WASH_LEVEL_SENSE_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign stage_o     = stage_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign aborted_o   = aborted_q;
    assign remaining_o = remaining_q;
    assign rinse_idx_o = rinse_idx_q;
`ifdef WASH_LEVEL_SENSE_EN
    assign fault_o     = fault_q;
`endif

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: directed programme scenarios plus randomized
// front-panel activity, checked every cycle against a queue-of-stages reference model.
module tb_wash_cycle_ctrl;
    localparam int CNT_W = 8, RPT_W = 3;
    localparam int T_FILL = 4, T_WASH = 6, T_RINSE = 3, T_SPIN = 5, N_RINSE = 2;
`ifdef WASH_LEVEL_SENSE_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0, ack = 1'b0, lvl = 1'b0;
    logic [2:0] stage_o;
    logic done_o, busy_o, aborted_o;
    logic [CNT_W-1:0] remaining_o;
    logic [RPT_W-1:0] rinse_idx_o;
`ifdef WASH_LEVEL_SENSE_EN
    logic fault_o;
`endif

    wash_cycle_ctrl #(.CNT_W(CNT_W), .FILL_TICKS(T_FILL), .WASH_TICKS(T_WASH),
                      .RINSE_TICKS(T_RINSE), .SPIN_TICKS(T_SPIN), .RINSE_CNT(N_RINSE),
                      .RPT_W(RPT_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause), .abort_i(abort), .ack_i(ack),
`ifdef WASH_LEVEL_SENSE_EN
        .level_ok_i(lvl), .fault_o(fault_o),
`endif
        .stage_o(stage_o), .done_o(done_o), .busy_o(busy_o), .aborted_o(aborted_o),
        .remaining_o(remaining_o), .rinse_idx_o(rinse_idx_o));

    int total = 0, bad = 0;
    bit chk_on = 1'b0;

    // Reference model: the programme is a queue of pending stages, each with cycles left.
    int q_st[$], q_left[$], q_ri[$];
    int m_stage = 0, m_rem = 0, m_ridx = 0;
    bit m_ab = 1'b0, m_fault = 1'b0;

    function automatic int tk(int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic push_stage(int st, int n, int ri);
        q_st.push_back(st); q_left.push_back(tk(n)); q_ri.push_back(ri);
    endtask

    task automatic pop_stage();
        void'(q_st.pop_front()); void'(q_left.pop_front()); void'(q_ri.pop_front());
    endtask

    task automatic clear_q();
        q_st.delete(); q_left.delete(); q_ri.delete();
    endtask

    task automatic model_step(bit s, bit p, bit a, bit k, bit r, bit l);
        bit active;
        bit frozen;
        active = (q_st.size() != 0);
        if (r) begin
            clear_q(); m_stage = 0; m_rem = 0; m_ridx = 0; m_ab = 0; m_fault = 0;
            return;
        end
        if (!active) begin
            if (m_stage == 0 && s && !p) begin
                push_stage(1, T_FILL, 0); push_stage(2, T_WASH, 0);
                for (int i = 0; i < N_RINSE; i++) push_stage(3, T_RINSE, i);
                push_stage(4, T_SPIN, N_RINSE - 1);
                m_ab = 0;
            end else if (m_stage == 5 && k) begin
                m_stage = 0;
            end else if (m_stage == 7 && k && !p) begin
                m_stage = 0; m_fault = 0;
            end
        end else begin
            frozen = p;
            if (a) begin
                m_ab = 1;
                if (q_st[0] != 4) begin
                    clear_q(); push_stage(4, T_SPIN, m_ridx); frozen = 1;
                end
            end
            if (!frozen) begin
                if (LVL && q_st[0] == 1 && l) pop_stage();
                else if (q_left[0] == 1) begin
                    if (LVL && q_st[0] == 1) begin clear_q(); m_fault = 1; end
                    else pop_stage();
                end else q_left[0]--;
            end
            if (q_st.size() == 0) m_stage = m_fault ? 7 : 5;
        end
        if (q_st.size() != 0) begin
            m_stage = q_st[0]; m_rem = q_left[0] - 1; m_ridx = q_ri[0];
        end else m_rem = 0;
    endtask

    task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 25) $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("stage", 32'(stage_o), 32'(m_stage));
            cmp("remaining", 32'(remaining_o), 32'(m_rem));
            cmp("rinse_idx", 32'(rinse_idx_o), 32'(m_ridx));
            cmp("aborted", 32'(aborted_o), 32'(m_ab));
            cmp("done", 32'(done_o), 32'(m_stage == 5));
            cmp("busy", 32'(busy_o), 32'(m_stage >= 1 && m_stage <= 4));
`ifdef WASH_LEVEL_SENSE_EN
            cmp("fault", 32'(fault_o), 32'(m_stage == 7));
`endif
        end
    end

    task automatic step(bit s, bit p, bit a, bit k, bit r);
        @(negedge clk);
        start = s; pause = p; abort = a; ack = k; rst = r;
        @(posedge clk);
        model_step(s, p, a, k, r, lvl);
        #1;
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_on = 1'b1;
        cmp("rst_stage", 32'(stage_o), 32'd0);
        cmp("rst_rem", 32'(remaining_o), 32'd0);

        // Full nominal programme.
        step(1, 0, 0, 0, 0);
        cmp("p1_fill", 32'(stage_o), 32'd1);
        cmp("p1_fill_rem", 32'(remaining_o), 32'd3);
        for (int e = 1; e <= 21; e++) begin
            step(0, 0, 0, 0, 0);
            if (e == 4) begin cmp("p1_wash", 32'(stage_o), 32'd2); cmp("p1_wash_rem", 32'(remaining_o), 32'd5); end
            if (e == 10) begin cmp("p1_rinse0", 32'(stage_o), 32'd3); cmp("p1_ridx0", 32'(rinse_idx_o), 32'd0); end
            if (e == 13) begin cmp("p1_rinse1", 32'(stage_o), 32'd3); cmp("p1_ridx1", 32'(rinse_idx_o), 32'd1); end
            if (e == 16) begin cmp("p1_spin", 32'(stage_o), 32'd4); cmp("p1_spin_rem", 32'(remaining_o), 32'd4); end
            if (e == 20) cmp("p1_notdone", 32'(done_o), 32'd0);
            if (e == 21) begin cmp("p1_done", 32'(done_o), 32'd1); cmp("p1_model_done", 32'(m_stage), 32'd5); end
        end
        step(0, 0, 0, 0, 0);
        cmp("p1_done_hold", 32'(stage_o), 32'd5);
        step(0, 0, 0, 1, 0);
        cmp("p1_idle", 32'(stage_o), 32'd0);

        // Pause three cycles in WASH.
        step(1, 0, 0, 0, 0);
        for (int e = 1; e <= 24; e++) begin
            step(0, (e >= 7 && e <= 9), 0, 0, 0);
            if (e == 9) begin cmp("p2_hold_st", 32'(stage_o), 32'd2); cmp("p2_hold_rem", 32'(remaining_o), 32'd3); cmp("p2_busy", 32'(busy_o), 32'd1); end
            if (e == 23) cmp("p2_notdone", 32'(done_o), 32'd0);
            if (e == 24) cmp("p2_done", 32'(done_o), 32'd1);
        end
        step(0, 0, 0, 1, 0);

        // Abort from WASH.
        step(1, 0, 0, 0, 0);
        for (int e = 1; e <= 13; e++) begin
            step(0, 0, (e == 8), 0, 0);
            if (e == 8) begin cmp("p3_spin", 32'(stage_o), 32'd4); cmp("p3_rem", 32'(remaining_o), 32'd4); cmp("p3_ab", 32'(aborted_o), 32'd1); end
            if (e == 13) cmp("p3_done", 32'(done_o), 32'd1);
        end
        step(0, 0, 0, 1, 0);
        cmp("p3_ab_kept", 32'(aborted_o), 32'd1);
        step(1, 0, 0, 0, 0);
        cmp("p3_ab_clr", 32'(aborted_o), 32'd0);
        step(0, 0, 0, 0, 1);

        // Abort with pause in RINSE; start and ack ignored in SPIN.
        step(1, 0, 0, 0, 0);
        idle_steps(10);
        step(0, 1, 1, 0, 0);
        cmp("p4_spin", 32'(stage_o), 32'd4);
        cmp("p4_rem", 32'(remaining_o), 32'd4);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        cmp("p4_ign_st", 32'(stage_o), 32'd4);
        cmp("p4_ign_rem", 32'(remaining_o), 32'd2);
        idle_steps(3);
        cmp("p4_done", 32'(done_o), 32'd1);
        step(0, 0, 0, 1, 0);

        // Reset mid-programme, then a full programme again.
        step(1, 0, 0, 0, 0);
        idle_steps(13);
        cmp("p5_ridx1", 32'(rinse_idx_o), 32'd1);
        step(0, 0, 0, 0, 1);
        cmp("p5_st0", 32'(stage_o), 32'd0);
        cmp("p5_ridx0", 32'(rinse_idx_o), 32'd0);
        cmp("p5_busy0", 32'(busy_o), 32'd0);
        step(1, 0, 0, 0, 0);
        idle_steps(20);
        cmp("p5_notdone", 32'(done_o), 32'd0);
        step(0, 0, 0, 0, 0);
        cmp("p5_done", 32'(done_o), 32'd1);
        step(0, 0, 0, 1, 0);

`ifdef WASH_LEVEL_SENSE_EN
        lvl = 1'b0;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        lvl = 1'b1;
        step(0, 0, 0, 0, 0);
        cmp("lv_early_wash", 32'(stage_o), 32'd2);
        lvl = 1'b0;
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        idle_steps(4);
        cmp("lv_fault_st", 32'(stage_o), 32'd7);
        cmp("lv_fault", 32'(fault_o), 32'd1);
        step(0, 0, 0, 1, 0);
        cmp("lv_fault_clr", 32'(stage_o), 32'd0);
`endif

        // Randomized front-panel activity.
        for (int i = 0; i < 4000; i++) begin
            lvl = ($urandom_range(0, 99) < 20);
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 999) < 5);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
- Parametrised washing-machine programme sequencer; successor to the fixed 4-cycle-per-stage controller.
- Stage durations and rinse repeat count are set per instance.
- Adds pause-with-resume, abort-to-spin, a done/ack handshake and countdown visibility.
- Sits between front-panel control inputs and the motor/valve drivers, which decode stage.

Parameters:
- CNT_W, 8, width of the stage countdown counter.
- FILL_TICKS, 4, FILL stage length in clk cycles (1..2^CNT_W).
- WASH_TICKS, 6, WASH stage length in cycles.
- RINSE_TICKS, 3, length of one RINSE pass in cycles.
- SPIN_TICKS, 5, SPIN stage length in cycles.
- RINSE_CNT, 2, number of consecutive RINSE passes (1..2^RPT_W-1).
- RPT_W, 3, width of rinse_idx.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level; begins a programme when sampled high in IDLE with pause=0.
- pause  in  1  level; freezes the active stage and counter while high.
- abort  in  1  level; jumps an active programme to SPIN.
- ack  in  1  one-cycle pulse; acknowledges DONE and returns to IDLE.
- stage  out  3  encoding: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5, FAULT=7 (FAULT only with the optional feature).
- done  out  1  high exactly while stage==DONE.
- busy  out  1  high in FILL, WASH, RINSE and SPIN.
- aborted  out  1  set when a programme was aborted; cleared on the next start.
- remaining  out  CNT_W  cycles left in the current stage, minus 1.
- rinse_idx  out  RPT_W  current rinse pass, 0-based.

Behaviour:
- All outputs registered. Reset values: stage=0, done=0, busy=0, aborted=0, remaining=0, rinse_idx=0.
- Priority at every edge: rst > abort > pause > normal counting.
- IDLE, start=1 and pause=0: next state FILL, remaining=FILL_TICKS-1, rinse_idx=0, aborted=0.
- start is ignored in every state other than IDLE.
- Active stage, pause=0, remaining!=0: remaining decrements by 1. Each stage is therefore visible for exactly N_TICKS cycles.
- Active stage, pause=0, remaining==0: advance and load the next stage's TICKS-1.
  - FILL -> WASH.
  - WASH -> RINSE.
  - RINSE with rinse_idx<RINSE_CNT-1 -> RINSE again, rinse_idx+1.
  - RINSE with rinse_idx==RINSE_CNT-1 -> SPIN.
  - SPIN -> DONE.
- Pause: stage, remaining and rinse_idx all hold. busy stays 1. Release resumes counting from the held value.
- Pause in IDLE blocks start. Pause in DONE has no effect.
- Abort in FILL, WASH or RINSE (paused or not): next state SPIN, remaining=SPIN_TICKS-1, aborted=1.
- Abort while already in SPIN: aborted=1, counting continues uninterrupted.
- Abort in IDLE, DONE or FAULT is ignored.
- DONE: holds until ack=1, then IDLE on the next edge. aborted is retained into IDLE.
- ack outside DONE/FAULT is ignored.
- Reset mid-programme returns to IDLE with all outputs at reset values on the next edge.
- A TICKS parameter of 0 is treated as 1.
- remaining is 0 in IDLE and DONE.

Optional Feature:
- Macro: WASH_LEVEL_SENSE_EN.
- Defined:
  - Adds input level_ok (1 bit, water-level sensor, synchronous to clk) and output fault (1 bit).
  - In FILL, the stage ends at the first edge where level_ok=1, even if remaining>0.
  - If remaining==0 and level_ok=0, next state FAULT: stage=7, fault=1, busy=0.
  - FAULT is left only by rst, or by ack together with pause=0, which go to IDLE. abort and start are ignored in FAULT.
  - pause still freezes the FILL timeout.
- Undefined: level_ok and fault ports are absent. FILL is purely timed. FAULT is unreachable.

Test Plan:
- Default params, start=1 for one cycle at edge 0 -> FILL for 4 cycles, WASH for 6, RINSE twice (rinse_idx 0 then 1, 3 cycles each), SPIN for 5; done=1 from edge 21 until ack, IDLE one edge after ack.
- Pause high for 3 cycles at WASH remaining=3 -> stage/remaining hold at 2/3 for those cycles; done rises at edge 24.
- Abort for 1 cycle at WASH remaining=2 -> SPIN next cycle with remaining=4, aborted=1; DONE 5 cycles later; the next start clears aborted.
- Simultaneous abort and pause during RINSE -> SPIN taken (abort wins); start during SPIN ignored; ack during SPIN ignored.
- rst at RINSE pass 1 -> IDLE next edge with all outputs 0; a following start gives the full 21-cycle programme again.
- WASH_LEVEL_SENSE_EN with level_ok=1 at FILL's second cycle -> WASH next edge. With level_ok held 0 -> FAULT after 4 FILL cycles, fault=1; ack -> IDLE.
